// File: rtl/register_file_pkg.sv
// Shared constants and state encoding for the register-file operand fetcher.
package register_file_pkg;

  localparam int unsigned REGISTER_DATA_WIDTH         = 8;
  localparam int unsigned DEFAULT_NUMBER_OF_REGISTERS = 256;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/register_file_operand_fetcher_if.sv
// Command, register-file read and operand-stream signals of the fetcher.
// master: the fetcher itself; slave: the surrounding command source, register file and datapath.
interface register_file_operand_fetcher_if
  import register_file_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int unsigned DATA_WIDTH          = REGISTER_DATA_WIDTH
);

  localparam int unsigned ADDR_W = $clog2(NUMBER_OF_REGISTERS);

  // Command channel
  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [ADDR_W-1:0] cmd_base_a_in;
  logic [ADDR_W-1:0] cmd_base_b_in;
  logic [ADDR_W:0]   cmd_length_in;
  logic              abort_in;

  // Register-file read ports (combinational read)
  logic [ADDR_W-1:0]     read_register_address1_out;
  logic [ADDR_W-1:0]     read_register_address2_out;
  logic [DATA_WIDTH-1:0] read_data1_in;
  logic [DATA_WIDTH-1:0] read_data2_in;

  // Operand stream to the datapath
  logic                  operand_valid_out;
  logic                  operand_ready_in;
  logic [DATA_WIDTH-1:0] operand_a_out;
  logic [DATA_WIDTH-1:0] operand_b_out;
  logic                  operand_last_out;

  // Status
  logic busy_out;
  logic done_out;

  modport master (
    input  cmd_valid_in, cmd_base_a_in, cmd_base_b_in, cmd_length_in, abort_in,
    input  read_data1_in, read_data2_in, operand_ready_in,
    output cmd_ready_out, read_register_address1_out, read_register_address2_out,
    output operand_valid_out, operand_a_out, operand_b_out, operand_last_out,
    output busy_out, done_out
  );

  modport slave (
    output cmd_valid_in, cmd_base_a_in, cmd_base_b_in, cmd_length_in, abort_in,
    output read_data1_in, read_data2_in, operand_ready_in,
    input  cmd_ready_out, read_register_address1_out, read_register_address2_out,
    input  operand_valid_out, operand_a_out, operand_b_out, operand_last_out,
    input  busy_out, done_out
  );

endinterface

// File: rtl/register_file_operand_fetcher.sv
// Read-side initiator for the register file: walks two address streams for a
// command and emits registered operand pairs over valid/ready, one per cycle.
module register_file_operand_fetcher
  import register_file_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int unsigned DATA_WIDTH          = REGISTER_DATA_WIDTH
) (
  input logic                            clock_in,
  input logic                            reset_n_in,
  register_file_operand_fetcher_if.master fetch_if
);

  localparam int unsigned ADDR_W = $clog2(NUMBER_OF_REGISTERS);
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  fetch_state_t          r_state;
  logic [ADDR_W-1:0]     r_base_a;
  logic [ADDR_W-1:0]     r_base_b;
  logic [ADDR_W:0]       r_length;
  logic [ADDR_W:0]       r_index;
  logic [ADDR_W-1:0]     r_addr1;
  logic [ADDR_W-1:0]     r_addr2;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_operand_a;
  logic [DATA_WIDTH-1:0] r_operand_b;
  logic                  r_last;
  logic                  r_done;

  logic                  w_issue;
  logic                  w_is_last;
  logic [ADDR_W:0]       w_next_index;

  // Issue whenever the output slice is empty or being drained this cycle.
  assign w_issue      = (r_state == FETCH) && (!r_valid || fetch_if.operand_ready_in);
  assign w_is_last    = (r_index == (r_length - LEN_ONE));
  assign w_next_index = r_index + LEN_ONE;

  // Sequencing FSM with the inline output register slice.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= IDLE;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_length    <= '0;
      r_index     <= '0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_valid     <= 1'b0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (fetch_if.abort_in) begin
        // Flush wins over everything, including a command offered this cycle.
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_index <= '0;
        r_addr1 <= '0;
        r_addr2 <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (fetch_if.cmd_valid_in) begin
              r_base_a <= fetch_if.cmd_base_a_in;
              r_base_b <= fetch_if.cmd_base_b_in;
              r_length <= fetch_if.cmd_length_in;
              r_index  <= '0;
              if (fetch_if.cmd_length_in == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= FETCH;
                r_addr1 <= fetch_if.cmd_base_a_in;
                r_addr2 <= fetch_if.cmd_base_b_in;
              end
            end
          end
          FETCH: begin
            // Without an issue the slice is stalled (valid && !ready): hold everything.
            if (w_issue) begin
              r_operand_a <= fetch_if.read_data1_in;
              r_operand_b <= fetch_if.read_data2_in;
              r_valid     <= 1'b1;
              r_last      <= w_is_last;
              r_index     <= w_next_index;
              if (w_is_last) begin
                r_state <= DRAIN;
                r_addr1 <= '0;
                r_addr2 <= '0;
              end else begin
                // Natural ADDR_W overflow gives the modulo wrap.
                r_addr1 <= r_base_a + w_next_index[ADDR_W-1:0];
                r_addr2 <= r_base_b + w_next_index[ADDR_W-1:0];
              end
            end
          end
          DRAIN: begin
            if (r_valid && fetch_if.operand_ready_in) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fetch_if.cmd_ready_out              = (r_state == IDLE);
  assign fetch_if.busy_out                   = (r_state != IDLE);
  assign fetch_if.read_register_address1_out = r_addr1;
  assign fetch_if.read_register_address2_out = r_addr2;
  assign fetch_if.operand_valid_out          = r_valid;
  assign fetch_if.operand_a_out              = r_operand_a;
  assign fetch_if.operand_b_out              = r_operand_b;
  assign fetch_if.operand_last_out           = r_last;
  assign fetch_if.done_out                   = r_done;

endmodule

// File: tb/tb_register_file_operand_fetcher.sv
// Directed bench for the operand fetcher with a behavioural 256x8 register file.
module tb_register_file_operand_fetcher;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] rf [256];
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  register_file_operand_fetcher_if #(.NUMBER_OF_REGISTERS(256), .DATA_WIDTH(8)) bus ();

  register_file_operand_fetcher #(.NUMBER_OF_REGISTERS(256), .DATA_WIDTH(8)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .fetch_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read; writes commit at the clock edge.
  assign bus.read_data1_in = rf[bus.read_register_address1_out];
  assign bus.read_data2_in = rf[bus.read_register_address2_out];

  initial begin
    for (int i = 0; i < 256; i++) rf[i] = i[7:0];
    forever begin
      @(posedge clk);
      if (wr_en) rf[wr_addr] <= wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one edge; returns in the cycle after acceptance.
  task automatic start_cmd(input logic [7:0] ba, input logic [7:0] bb, input logic [8:0] len);
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_base_a_in = ba;
    bus.cmd_base_b_in = bb;
    bus.cmd_length_in = len;
    tick();
    bus.cmd_valid_in  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out,
         bus.done_out, bus.busy_out, bus.read_register_address1_out,
         bus.read_register_address2_out} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%h b=%h l=%b d=%b busy=%b a1=%h a2=%h exp all 0",
               bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out,
               bus.operand_last_out, bus.done_out, bus.busy_out,
               bus.read_register_address1_out, bus.read_register_address2_out);
    end
    checks++;
    if (bus.cmd_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.busy_out, bus.done_out, bus.operand_valid_out, bus.cmd_ready_out} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_release got busy=%b done=%b valid=%b rdy=%b exp 0 0 0 1",
               bus.busy_out, bus.done_out, bus.operand_valid_out, bus.cmd_ready_out);
    end
  endtask

  task automatic test_streaming();
    bus.operand_ready_in = 1'b1;
    start_cmd(8'h10, 8'h80, 9'd4);
    checks++;
    if ({bus.read_register_address1_out, bus.read_register_address2_out, bus.operand_valid_out,
         bus.busy_out, bus.cmd_ready_out} !== {8'h10, 8'h80, 3'b010}) begin
      errors++;
      $display("FAIL stream_addr got a1=%h a2=%h v=%b busy=%b rdy=%b exp 10 80 0 1 0",
               bus.read_register_address1_out, bus.read_register_address2_out,
               bus.operand_valid_out, bus.busy_out, bus.cmd_ready_out);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out,
           bus.done_out} !== {1'b1, 8'h10 + k[7:0], 8'h80 + k[7:0], k == 3, 1'b0}) begin
        errors++;
        $display("FAIL stream_pair[%0d] got v=%b a=%h b=%h l=%b d=%b exp 1 %h %h %b 0", k,
                 bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out,
                 bus.operand_last_out, bus.done_out, 8'h10 + k[7:0], 8'h80 + k[7:0], k == 3);
      end
    end
    tick();
    checks++;
    if ({bus.done_out, bus.operand_valid_out, bus.busy_out} !== 3'b100) begin
      errors++;
      $display("FAIL stream_done got d=%b v=%b busy=%b exp 1 0 0",
               bus.done_out, bus.operand_valid_out, bus.busy_out);
    end
    tick();
    checks++;
    if (bus.done_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_pulse got %b exp 0", bus.done_out);
    end
  endtask

  task automatic test_wrap_backpressure();
    bus.operand_ready_in = 1'b1;
    start_cmd(8'hFE, 8'h00, 9'd3);
    checks++;
    if ({bus.read_register_address1_out, bus.read_register_address2_out} !== 16'hFE00) begin
      errors++;
      $display("FAIL wrap_addr0 got %h %h exp fe 00",
               bus.read_register_address1_out, bus.read_register_address2_out);
    end
    tick();
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out} !== {1'b1, 16'hFE00}) begin
      errors++;
      $display("FAIL wrap_pair0 got v=%b a=%h b=%h exp 1 fe 00",
               bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out,
           bus.read_register_address1_out, bus.read_register_address2_out}
          !== {1'b1, 16'hFF01, 1'b0, 16'h0002}) begin
        errors++;
        $display("FAIL wrap_hold[%0d] got v=%b a=%h b=%h l=%b a1=%h a2=%h exp 1 ff 01 0 00 02",
                 c, bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out,
                 bus.operand_last_out, bus.read_register_address1_out,
                 bus.read_register_address2_out);
      end
      bus.operand_ready_in = (c == 2);
      if (c < 2) tick();
    end
    tick();
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out}
        !== {1'b1, 16'h0002, 1'b1}) begin
      errors++;
      $display("FAIL wrap_pair2 got v=%b a=%h b=%h l=%b exp 1 00 02 1",
               bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out);
    end
    tick();
    checks++;
    if ({bus.done_out, bus.operand_valid_out} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_done got d=%b v=%b exp 1 0", bus.done_out, bus.operand_valid_out);
    end
  endtask

  task automatic test_edge_lengths();
    bus.operand_ready_in = 1'b1;
    start_cmd(8'h33, 8'h44, 9'd0);
    checks++;
    if ({bus.done_out, bus.operand_valid_out, bus.busy_out, bus.cmd_ready_out} !== 4'b1001) begin
      errors++;
      $display("FAIL len0 got d=%b v=%b busy=%b rdy=%b exp 1 0 0 1",
               bus.done_out, bus.operand_valid_out, bus.busy_out, bus.cmd_ready_out);
    end
    tick();
    checks++;
    if ({bus.done_out, bus.operand_valid_out} !== 2'b00) begin
      errors++;
      $display("FAIL len0_after got d=%b v=%b exp 0 0", bus.done_out, bus.operand_valid_out);
    end
    start_cmd(8'h00, 8'h00, 9'd256);
    for (int k = 0; k < 256; k++) begin
      tick();
      checks++;
      if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out}
          !== {1'b1, k[7:0], k[7:0], k == 255}) begin
        errors++;
        $display("FAIL len256_pair[%0d] got v=%b a=%h b=%h l=%b exp 1 %h %h %b", k,
                 bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out,
                 bus.operand_last_out, k[7:0], k[7:0], k == 255);
      end
    end
    tick();
    checks++;
    if ({bus.done_out, bus.operand_valid_out, bus.busy_out} !== 3'b100) begin
      errors++;
      $display("FAIL len256_done got d=%b v=%b busy=%b exp 1 0 0",
               bus.done_out, bus.operand_valid_out, bus.busy_out);
    end
    tick();
  endtask

  task automatic test_abort();
    bus.operand_ready_in = 1'b1;
    start_cmd(8'h10, 8'h80, 9'd5);
    tick();
    tick();
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL abort_pre got v=%b a=%h exp 1 11", bus.operand_valid_out, bus.operand_a_out);
    end
    bus.abort_in      = 1'b1;
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_base_a_in = 8'h40;
    bus.cmd_base_b_in = 8'h40;
    bus.cmd_length_in = 9'd2;
    tick();
    bus.abort_in     = 1'b0;
    bus.cmd_valid_in = 1'b0;
    checks++;
    if ({bus.operand_valid_out, bus.operand_last_out, bus.busy_out, bus.done_out,
         bus.cmd_ready_out} !== 5'b00001) begin
      errors++;
      $display("FAIL abort_flush got v=%b l=%b busy=%b d=%b rdy=%b exp 0 0 0 0 1",
               bus.operand_valid_out, bus.operand_last_out, bus.busy_out, bus.done_out,
               bus.cmd_ready_out);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.operand_valid_out, bus.busy_out, bus.done_out,
           bus.read_register_address1_out} !== 11'd0) begin
        errors++;
        $display("FAIL abort_idle[%0d] got v=%b busy=%b d=%b a1=%h exp 0 0 0 00", c,
                 bus.operand_valid_out, bus.busy_out, bus.done_out,
                 bus.read_register_address1_out);
      end
    end
  endtask

  task automatic test_write_collision();
    bus.operand_ready_in = 1'b1;
    start_cmd(8'h20, 8'h00, 9'd1);
    checks++;
    if (bus.read_register_address1_out !== 8'h20) begin
      errors++;
      $display("FAIL coll_addr got %h exp 20", bus.read_register_address1_out);
    end
    wr_en   = 1'b1;
    wr_addr = 8'h20;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_last_out} !== {1'b1, 8'h20, 1'b1})
    begin
      errors++;
      $display("FAIL coll_old got v=%b a=%h l=%b exp 1 20 1",
               bus.operand_valid_out, bus.operand_a_out, bus.operand_last_out);
    end
    tick();
    start_cmd(8'h20, 8'h00, 9'd1);
    tick();
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out} !== {1'b1, 8'h55}) begin
      errors++;
      $display("FAIL coll_new got v=%b a=%h exp 1 55", bus.operand_valid_out, bus.operand_a_out);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bus.operand_ready_in = 1'b0;
    start_cmd(8'h10, 8'h80, 9'd4);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out, bus.operand_last_out,
         bus.done_out, bus.busy_out, bus.read_register_address1_out,
         bus.read_register_address2_out, bus.cmd_ready_out} !== 38'd1) begin
      errors++;
      $display("FAIL midreset got v=%b a=%h b=%h l=%b d=%b busy=%b a1=%h a2=%h rdy=%b exp 0..0 1",
               bus.operand_valid_out, bus.operand_a_out, bus.operand_b_out,
               bus.operand_last_out, bus.done_out, bus.busy_out,
               bus.read_register_address1_out, bus.read_register_address2_out,
               bus.cmd_ready_out);
    end
    tick();
    rst_n = 1'b1;
    bus.operand_ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({bus.done_out, bus.busy_out, bus.operand_valid_out} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_release[%0d] got d=%b busy=%b v=%b exp 0 0 0", c,
                 bus.done_out, bus.busy_out, bus.operand_valid_out);
      end
    end
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    rst_n                = 1'b0;
    wr_en                = 1'b0;
    wr_addr              = 8'h00;
    wr_data              = 8'h00;
    bus.cmd_valid_in     = 1'b0;
    bus.cmd_base_a_in    = 8'h00;
    bus.cmd_base_b_in    = 8'h00;
    bus.cmd_length_in    = 9'd0;
    bus.abort_in         = 1'b0;
    bus.operand_ready_in = 1'b0;

    test_reset();
    test_streaming();
    test_wrap_backpressure();
    test_edge_lengths();
    test_abort();
    test_write_collision();
    test_reset_mid_fetch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
